// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the VGA timing generator, the ASIP data port and the
// image RAM. The arbiter takes the slave view; the environment takes master.
interface vga_mem_arbiter_if #(
    parameter int DATA_W = 8
);
    // display read path
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              CHG_IMG;
    logic              disp_req;
    logic [DATA_W-1:0] disp_pixel;
    logic              disp_valid;
    logic              disp_miss;
    // core load/store path
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    // image RAM port
    logic [31:0]       mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  pos_x, pos_y, CHG_IMG, disp_req,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata,
        output disp_pixel, disp_valid, disp_miss,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output pos_x, pos_y, CHG_IMG, disp_req,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata,
        input  disp_pixel, disp_valid, disp_miss,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Arbiter for the single-port image RAM: display reads have priority, a
// starvation guard forces a core slot after MAX_WAIT denied cycles.
// Optional build macro VGA_ADDR_CLAMP_EN: out-of-range display positions
// skip the RAM, return pixel 0 and hand the slot to the core.
module vga_mem_arbiter #(
    parameter int DATA_W   = 8,
    parameter int W_ENC    = 640,
    parameter int W_DEC    = 320,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_CPU} grant_e;

    grant_e            winner;
    logic [31:0]       row_w;
    logic [17:0]       pix_off;
    logic [31:0]       disp_addr;
    logic              disp_in_range;
    logic              starve;

    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic              mem_we_q,     mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              rd_disp_q,    rd_disp_d;   // owner tag: display read in flight
    logic              rd_cpu_q,     rd_cpu_d;    // owner tag: core read in flight
    logic              miss_q,       miss_d;      // display slot given to the core
    logic              clamp_q,      clamp_d;     // display answered without RAM
    logic [DATA_W-1:0] disp_pixel_q, disp_pixel_d;
    logic              disp_valid_q, disp_valid_d;
    logic              disp_miss_q,  disp_miss_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [7:0]        wait_cnt_q,   wait_cnt_d;

    // Linear pixel address; bits above 17 fall off, CHG_IMG selects the bank.
    assign row_w     = bus.CHG_IMG ? 32'(W_DEC) : 32'(W_ENC);
    assign pix_off   = 18'(row_w * 32'(bus.pos_y) + 32'(bus.pos_x));
    assign disp_addr = {13'b0, bus.CHG_IMG, pix_off};

`ifdef VGA_ADDR_CLAMP_EN
    localparam int H_ENC = 400;
    localparam int H_DEC = 320;
    logic [31:0] row_h;
    assign row_h         = bus.CHG_IMG ? 32'(H_DEC) : 32'(H_ENC);
    assign disp_in_range = (32'(bus.pos_x) < row_w) && (32'(bus.pos_y) < row_h);
`else
    assign disp_in_range = 1'b1;
`endif

    assign starve  = bus.cpu_req && (wait_cnt_q == 8'(MAX_WAIT));
    assign bus.cpu_gnt = (winner == GNT_CPU);

    // Pick this cycle's RAM owner; nobody is granted while reset is held.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path infers a latch.
        winner = GNT_IDLE;
        if (rst_n) begin
            if (bus.disp_req && disp_in_range && !starve) winner = GNT_DISP;
            else if (bus.cpu_req)                         winner = GNT_CPU;
        end
    end

    // Next state for the address stage, the data stage and the wait counter.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        rd_disp_d   = 1'b0;
        rd_cpu_d    = 1'b0;
        miss_d      = 1'b0;
        clamp_d     = bus.disp_req && !disp_in_range;
        case (winner)
            GNT_DISP: begin
                mem_addr_d = disp_addr;
                rd_disp_d  = 1'b1;
            end
            GNT_CPU: begin
                mem_addr_d  = bus.cpu_addr;
                mem_we_d    = bus.cpu_we;
                mem_wdata_d = bus.cpu_wdata;
                rd_cpu_d    = !bus.cpu_we;
                miss_d      = bus.disp_req && disp_in_range;
            end
            default: ;
        endcase

        // Data stage: mem_rdata belongs to whichever tag was set last edge.
        disp_valid_d = rd_disp_q || clamp_q;
        disp_miss_d  = miss_q;
        disp_pixel_d = disp_pixel_q;
        if (rd_disp_q)    disp_pixel_d = bus.mem_rdata;
        else if (clamp_q) disp_pixel_d = '0;
        cpu_rvalid_d = rd_cpu_q;
        cpu_rdata_d  = rd_cpu_q ? bus.mem_rdata : cpu_rdata_q;

        // Count denied core cycles; saturate so the guard stays armed.
        if (!bus.cpu_req || winner == GNT_CPU) wait_cnt_d = '0;
        else if (wait_cnt_q != 8'(MAX_WAIT))    wait_cnt_d = wait_cnt_q + 8'd1;
        else                                    wait_cnt_d = wait_cnt_q;
    end

    // All state, including in-flight tags, is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            rd_disp_q    <= 1'b0;
            rd_cpu_q     <= 1'b0;
            miss_q       <= 1'b0;
            clamp_q      <= 1'b0;
            disp_pixel_q <= '0;
            disp_valid_q <= 1'b0;
            disp_miss_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_disp_q    <= rd_disp_d;
            rd_cpu_q     <= rd_cpu_d;
            miss_q       <= miss_d;
            clamp_q      <= clamp_d;
            disp_pixel_q <= disp_pixel_d;
            disp_valid_q <= disp_valid_d;
            disp_miss_q  <= disp_miss_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_pixel = disp_pixel_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_miss  = disp_miss_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: vector table for single-cycle arbitration and
// addressing, scoreboard queues for read returns, hand-written sequences for
// starvation and reset. Honors VGA_ADDR_CLAMP_EN if defined.
module tb_vga_mem_arbiter;
    localparam int DATA_W   = 8;
    localparam int MAX_WAIT = 8;
    localparam int N_VEC    = 17;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] cyc = '0;
    int checks = 0;
    int failures = 0;

    vga_mem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    vga_mem_arbiter #(
        .DATA_W(DATA_W), .W_ENC(640), .W_DEC(320), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // RAM model: combinational read of the registered address.
    function automatic logic [7:0] mem_model(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'hA5;
    endfunction
    always_comb bus.mem_rdata = mem_model(bus.mem_addr);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected returns with the cycle they must appear in.
    typedef struct packed {
        logic        miss;
        logic [7:0]  pix;
        logic [31:0] due;
    } sb_ent_t;
    sb_ent_t sb_disp[$];
    sb_ent_t sb_cpu[$];
    sb_ent_t de, ce;
    logic [7:0] last_pix = '0;

    task automatic push_disp(input logic miss, input logic [7:0] pix);
        sb_disp.push_back('{miss, pix, cyc + 32'd2});
        if (!miss) last_pix = pix;
    endtask

    task automatic push_cpu(input logic [7:0] d);
        sb_cpu.push_back('{1'b0, d, cyc + 32'd2});
    endtask

    // Pop and compare returns between edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.disp_valid || bus.disp_miss) begin
                if (sb_disp.size() == 0) begin
                    check("disp_unexpected", {bus.disp_valid, bus.disp_miss}, 0);
                end else begin
                    de = sb_disp.pop_front();
                    check("disp_kind", {bus.disp_valid, bus.disp_miss},
                          de.miss ? 32'd1 : 32'd2);
                    check("disp_pixel", bus.disp_pixel, de.pix);
                    check("disp_latency", cyc, de.due);
                end
            end else if (sb_disp.size() != 0 && sb_disp[0].due <= cyc) begin
                de = sb_disp.pop_front();
                check("disp_missing_pulse", cyc, de.due + 32'd1000);
            end
            if (bus.cpu_rvalid) begin
                if (sb_cpu.size() == 0) begin
                    check("cpu_unexpected_rvalid", bus.cpu_rvalid, 0);
                end else begin
                    ce = sb_cpu.pop_front();
                    check("cpu_rdata", bus.cpu_rdata, ce.pix);
                    check("cpu_latency", cyc, ce.due);
                end
            end else if (sb_cpu.size() != 0 && sb_cpu[0].due <= cyc) begin
                ce = sb_cpu.pop_front();
                check("cpu_missing_rvalid", cyc, ce.due + 32'd1000);
            end
        end
    end

    typedef struct packed {
        logic        dr;
        logic [9:0]  px, py;
        logic        chg;
        logic        cr, cw;
        logic [31:0] ca;
        logic [7:0]  cd;
        logic        eg, ew;
        logic [31:0] ea;
        logic [1:0]  ed;   // display return: 0 none, 1 RAM pixel, 2 clamped zero
    } vec_t;
    vec_t tbl [N_VEC];

    function automatic vec_t mk(input logic dr, input logic [9:0] px, py,
                                input logic chg, input logic cr, cw,
                                input logic [31:0] ca, input logic [7:0] cd,
                                input logic eg, ew, input logic [31:0] ea,
                                input logic [1:0] ed);
        return '{dr, px, py, chg, cr, cw, ca, cd, eg, ew, ea, ed};
    endfunction

    task automatic drive_idle();
        bus.disp_req = 1'b0; bus.pos_x = '0; bus.pos_y = '0; bus.CHG_IMG = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"},   bus.mem_addr,   0);
        check({tag, "_mem_we"},     bus.mem_we,     0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,  0);
        check({tag, "_disp_pixel"}, bus.disp_pixel, 0);
        check({tag, "_disp_valid"}, bus.disp_valid, 0);
        check({tag, "_disp_miss"},  bus.disp_miss,  0);
        check({tag, "_cpu_rdata"},  bus.cpu_rdata,  0);
        check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        check({tag, "_cpu_gnt"},    bus.cpu_gnt,    0);
    endtask

    initial begin
        //          dr px   py   chg cr cw ca            cd     eg ew ea            ed
        tbl[0]  = mk(1, 5,   2,   0,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00000505, 1);
        tbl[1]  = mk(1, 5,   2,   1,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00040285, 1);
        tbl[2]  = mk(0, 0,   0,   0,  1, 1, 32'h100,      8'h3C, 1, 1, 32'h00000100, 0);
        tbl[3]  = mk(0, 0,   0,   0,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00000100, 0);
        tbl[4]  = mk(0, 0,   0,   0,  1, 0, 32'h2A0,      8'h00, 1, 0, 32'h000002A0, 0);
        tbl[5]  = mk(1, 639, 399, 0,  0, 0, 32'h0,        8'h00, 0, 0, 32'h0003E7FF, 1);
        tbl[6]  = mk(1, 0,   0,   0,  1, 0, 32'h77,       8'h00, 0, 0, 32'h00000000, 1);
        tbl[7]  = mk(0, 0,   0,   0,  1, 0, 32'h77,       8'h00, 1, 0, 32'h00000077, 0);
        tbl[8]  = mk(1, 10,  3,   1,  0, 0, 32'h0,        8'h00, 0, 0, 32'h000403CA, 1);
        tbl[9]  = mk(0, 0,   0,   0,  1, 0, 32'h1234,     8'h00, 1, 0, 32'h00001234, 0);
        tbl[10] = mk(1, 319, 319, 1,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00058FFF, 1);
        tbl[11] = mk(0, 0,   0,   0,  1, 1, 32'hDEAD,     8'h5A, 1, 1, 32'h0000DEAD, 0);
        tbl[12] = mk(0, 0,   0,   0,  1, 0, 32'hFFFFFFFF, 8'h00, 1, 0, 32'hFFFFFFFF, 0);
`ifdef VGA_ADDR_CLAMP_EN
        tbl[13] = mk(1, 0,   410, 0,  0, 0, 32'h0,        8'h00, 0, 0, 32'hFFFFFFFF, 2);
        tbl[14] = mk(1, 330, 0,   1,  1, 0, 32'h55,       8'h00, 1, 0, 32'h00000055, 2);
        tbl[15] = mk(1, 330, 0,   1,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00000055, 2);
`else
        tbl[13] = mk(1, 0,   410, 0,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00000100, 1);
        tbl[14] = mk(1, 330, 0,   1,  1, 0, 32'h55,       8'h00, 0, 0, 32'h0004014A, 1);
        tbl[15] = mk(0, 0,   0,   0,  1, 0, 32'h55,       8'h00, 1, 0, 32'h00000055, 0);
`endif
        tbl[16] = mk(0, 0,   0,   0,  0, 0, 32'h0,        8'h00, 0, 0, 32'h00000055, 0);

        // Reset state, with requests asserted to confirm no grant leaks out.
        rst_n = 1'b0;
        drive_idle();
        bus.disp_req = 1'b1;
        bus.cpu_req  = 1'b1;
        #12;
        check_all_zero("reset");
        drive_idle();
        #10 rst_n = 1'b1;

        // Vector table: one request set per cycle, pipelined back to back.
        @(posedge clk); #1;
        for (int i = 0; i < N_VEC; i++) begin
            bus.disp_req  = tbl[i].dr;  bus.pos_x  = tbl[i].px;
            bus.pos_y     = tbl[i].py;  bus.CHG_IMG = tbl[i].chg;
            bus.cpu_req   = tbl[i].cr;  bus.cpu_we = tbl[i].cw;
            bus.cpu_addr  = tbl[i].ca;  bus.cpu_wdata = tbl[i].cd;
            if (tbl[i].ed == 2'd1) push_disp(1'b0, mem_model(tbl[i].ea));
            if (tbl[i].ed == 2'd2) push_disp(1'b0, 8'h00);
            if (tbl[i].eg && !tbl[i].ew) push_cpu(mem_model(tbl[i].ea));
            #3;
            check($sformatf("row%0d_cpu_gnt", i), bus.cpu_gnt, tbl[i].eg);
            @(posedge clk); #1;
            check($sformatf("row%0d_mem_addr", i), bus.mem_addr, tbl[i].ea);
            check($sformatf("row%0d_mem_we", i), bus.mem_we, tbl[i].ew);
            if (tbl[i].ew)
                check($sformatf("row%0d_mem_wdata", i), bus.mem_wdata, tbl[i].cd);
        end
        drive_idle();
        repeat (3) @(posedge clk);
        #1;

        // Starvation: display held, core read waits MAX_WAIT cycles then wins.
        bus.disp_req = 1'b1; bus.pos_x = 10'd1; bus.pos_y = 10'd1; bus.CHG_IMG = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h300;
        for (int c = 0; c <= MAX_WAIT; c++) begin
            if (c < MAX_WAIT) begin
                push_disp(1'b0, mem_model(32'h281));
            end else begin
                push_disp(1'b1, last_pix);
                push_cpu(mem_model(32'h300));
            end
            #3;
            check($sformatf("starve%0d_cpu_gnt", c), bus.cpu_gnt, (c == MAX_WAIT));
            @(posedge clk); #1;
            check($sformatf("starve%0d_mem_addr", c), bus.mem_addr,
                  (c == MAX_WAIT) ? 32'h300 : 32'h281);
        end
        drive_idle();
        repeat (4) @(posedge clk);
        #1;

        // Reset while a core read is in flight: everything drops at once and
        // the discarded read never returns.
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h4444;
        @(posedge clk); #1;
        check("inflight_mem_addr", bus.mem_addr, 32'h4444);
        bus.disp_req = 1'b1; bus.pos_x = 10'd5; bus.pos_y = 10'd2;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb_disp.delete();
        sb_cpu.delete();
        repeat (2) @(posedge clk);
        drive_idle();
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_mem_addr", bus.mem_addr, 0);

        check("sb_disp_drained", sb_disp.size(), 0);
        check("sb_cpu_drained", sb_cpu.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
